// File: rtl/adder_cla_pkg.sv
// Shared constants for the two-level carry-lookahead adder.
package adder_cla_pkg;

   // Default operand width and lookahead group size
   localparam int CLA_WIDTH = 32;
   localparam int CLA_GRP   = 4;

   // Number of lookahead groups at the default sizing
   localparam int CLA_NGRP  = CLA_WIDTH / CLA_GRP;

endpackage

// File: rtl/cla_group.sv
// One GRP-bit carry-lookahead slice.
// Produces the sum bits for its slice and exports group generate/propagate
// so the parent can resolve inter-group carries in a second lookahead level.
module cla_group
   import adder_cla_pkg::*;
#(
   parameter int GRP = CLA_GRP
) (
   input  logic [GRP-1:0] a,
   input  logic [GRP-1:0] b,
   input  logic           cin,
   output logic [GRP-1:0] s,
   output logic           G,
   output logic           P
);

   logic [GRP-1:0] g;
   logic [GRP-1:0] p;
   logic [GRP-1:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Flat sum-of-products carries: c[k] = OR_j(g[j] & p[j+1..k-1]) | (p[0..k-1] & cin)
   always_comb begin
      logic prod;
      logic acc;
      prod = 1'b0;
      acc  = 1'b0;
      c    = '0;
      c[0] = cin;
      for (int k = 1; k < GRP; k++) begin
         acc = cin;
         for (int j = 0; j < k; j++) acc = acc & p[j];
         for (int j = 0; j < k; j++) begin
            prod = g[j];
            for (int m = j + 1; m < k; m++) prod = prod & p[m];
            acc = acc | prod;
         end
         c[k] = acc;
      end
   end

   // Group generate/propagate over the whole slice, independent of cin
   always_comb begin
      logic prod;
      logic acc;
      prod = 1'b0;
      acc  = 1'b0;
      for (int j = 0; j < GRP; j++) begin
         prod = g[j];
         for (int m = j + 1; m < GRP; m++) prod = prod & p[m];
         acc = acc | prod;
      end
      G = acc;
      P = &p;
   end

   assign s = p ^ c;

endmodule

// File: rtl/adder_cla.sv
// Two-level carry-lookahead adder with a combinational result and a
// one-cycle registered copy. Groups compute local lookahead; the carries
// into each group come from a second lookahead over the group G/P terms.
module adder_cla
   import adder_cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int GRP   = CLA_GRP
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c,
   output logic [WIDTH-1:0] o_s,
   output logic             o_c,
   output logic [WIDTH-1:0] o_s_r,
   output logic             o_c_r
);

   localparam int NGRP = WIDTH / GRP;

   logic [NGRP-1:0] grp_g;
   logic [NGRP-1:0] grp_p;
   logic [NGRP:0]   grp_c;

   // Second-level lookahead: carry into group k from group G/P and i_c
   always_comb begin
      logic prod;
      logic acc;
      prod     = 1'b0;
      acc      = 1'b0;
      grp_c    = '0;
      grp_c[0] = i_c;
      for (int k = 1; k <= NGRP; k++) begin
         acc = i_c;
         for (int j = 0; j < k; j++) acc = acc & grp_p[j];
         for (int j = 0; j < k; j++) begin
            prod = grp_g[j];
            for (int m = j + 1; m < k; m++) prod = prod & grp_p[m];
            acc = acc | prod;
         end
         grp_c[k] = acc;
      end
   end

   for (genvar i = 0; i < NGRP; i++) begin : g_grp
      cla_group #(.GRP(GRP)) u_grp (
         .a   (i_a[i*GRP +: GRP]),
         .b   (i_b[i*GRP +: GRP]),
         .cin (grp_c[i]),
         .s   (o_s[i*GRP +: GRP]),
         .G   (grp_g[i]),
         .P   (grp_p[i])
      );
   end

   assign o_c = grp_c[NGRP];

   // Registered copy of the sum; cleared immediately by reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_s_r <= '0;
         o_c_r <= 1'b0;
      end else begin
         o_s_r <= o_s;
         o_c_r <= o_c;
      end
   end

endmodule

// File: tb/tb_adder_cla.sv
// Scoreboard bench for adder_cla: expected {carry,sum} pushed at drive time,
// popped when the combinational or registered output is sampled.
module tb_adder_cla;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          ci = 1'b0;
   logic [W-1:0]  s;
   logic          co;
   logic [W-1:0]  s_r;
   logic          co_r;

   int n_cmp = 0;
   int n_err = 0;

   logic [W:0] sb_q[$];

   adder_cla #(.WIDTH(W), .GRP(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_a   (a),
      .i_b   (b),
      .i_c   (ci),
      .o_s   (s),
      .o_c   (co),
      .o_s_r (s_r),
      .o_c_r (co_r)
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic z);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, z};
   endfunction

   task automatic test_reset();
      logic [W:0] exp;
      a = 32'd5; b = 32'd6; ci = 1'b0;
      sb_q.push_back(33'd11);
      @(posedge clk); #1;
      n_cmp++;
      if ({co_r, s_r} !== 33'd0) begin
         n_err++; $display("FAIL reset_reg got=%h want=0", {co_r, s_r});
      end
      exp = sb_q.pop_front();
      n_cmp++;
      if ({co, s} !== exp) begin
         n_err++; $display("FAIL reset_comb got=%h want=%h", {co, s}, exp);
      end
   endtask

   task automatic test_corners();
      logic [W-1:0] ta[5];
      logic [W-1:0] tb_[5];
      logic         tc[5];
      logic [W:0]   exp;
      ta[0] = 32'h0;        tb_[0] = 32'h0;        tc[0] = 1'b0; sb_q.push_back({1'b0, 32'h00000000});
      ta[1] = 32'hFFFFFFFF; tb_[1] = 32'h0;        tc[1] = 1'b1; sb_q.push_back({1'b1, 32'h00000000});
      ta[2] = 32'hFFFFFFFF; tb_[2] = 32'hFFFFFFFF; tc[2] = 1'b1; sb_q.push_back({1'b1, 32'hFFFFFFFF});
      ta[3] = 32'h12345678; tb_[3] = 32'h87654321; tc[3] = 1'b0; sb_q.push_back({1'b0, 32'h99999999});
      ta[4] = 32'h80000000; tb_[4] = 32'h80000000; tc[4] = 1'b0; sb_q.push_back({1'b1, 32'h00000000});
      for (int i = 0; i < 5; i++) begin
         a = ta[i]; b = tb_[i]; ci = tc[i];
         #1;
         exp = sb_q.pop_front();
         n_cmp++;
         if ({co, s} !== exp) begin
            n_err++; $display("FAIL corner%0d got=%h want=%h", i, {co, s}, exp);
         end
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      rst = 1'b0;
      a = 32'd1; b = 32'd2; ci = 1'b0;
      sb_q.push_back(33'd3);
      @(posedge clk); #1;
      n_cmp++;
      if ({co_r, s_r} !== sb_q[0]) begin
         n_err++; $display("FAIL reg_load got=%h want=%h", {co_r, s_r}, sb_q[0]);
      end
      void'(sb_q.pop_front());
      // Reset between edges: registered clears at once, comb keeps tracking
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({co_r, s_r} !== 33'd0) begin
         n_err++; $display("FAIL reg_async_clr got=%h want=0", {co_r, s_r});
      end
      n_cmp++;
      if ({co, s} !== 33'd3) begin
         n_err++; $display("FAIL comb_in_reset got=%h want=3", {co, s});
      end
      // First edge after release loads the current sum
      @(negedge clk);
      rst = 1'b0;
      a = 32'hFFFFFFF0; b = 32'h00000020; ci = 1'b1;
      sb_q.push_back({1'b1, 32'h00000011});
      @(posedge clk); #1;
      n_cmp++;
      if ({co_r, s_r} !== sb_q[0]) begin
         n_err++; $display("FAIL reg_after_rst got=%h want=%h", {co_r, s_r}, sb_q[0]);
      end
      void'(sb_q.pop_front());
   endtask

   task automatic test_random();
      logic [W:0] exp;
      for (int i = 0; i < 24; i++) begin
         a  = $urandom;
         b  = (i % 4 == 0) ? ~a : $urandom;
         ci = 1'($urandom_range(0, 1));
         sb_q.push_back(ref_sum(a, b, ci));
         #1;
         exp = sb_q.pop_front();
         n_cmp++;
         if ({co, s} !== exp) begin
            n_err++; $display("FAIL rand%0d a=%h b=%h c=%b got=%h want=%h", i, a, b, ci, {co, s}, exp);
         end
         #3;
      end
   endtask

   task automatic test_back_to_back();
      logic [W:0] exp;
      // Drive a new vector every cycle; each registered result lags by one edge
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         a  = $urandom;
         b  = $urandom;
         ci = 1'($urandom_range(0, 1));
         sb_q.push_back(ref_sum(a, b, ci));
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         n_cmp++;
         if ({co_r, s_r} !== exp) begin
            n_err++; $display("FAIL b2b%0d got=%h want=%h", i, {co_r, s_r}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_corners();
      test_registered();
      test_random();
      test_back_to_back();
      if (sb_q.size() != 0) begin
         n_err++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running want=done");
      $fatal(1, "timeout");
   end

endmodule
